// File: rtl/bm_dag_pipe_param.sv
// Multi-channel registered DAG benchmark: shared operands fan out to CHANNELS
// delay lines, then a mode-selected registered reduction recombines them.
module bm_dag_pipe_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int OP    = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DEPTH-1:0] i_ld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_a_d1,
  output logic [WIDTH-1:0] o_fin
);
  logic [DEPTH-1:0][WIDTH-1:0] r_stg;
  logic [WIDTH-1:0]            w_t;

  always_comb begin
    case (OP)
      0:       w_t = i_a & i_b;
      1:       w_t = i_a | i_b;
      2:       w_t = i_a ^ i_b;
      default: w_t = ~(i_a ^ i_b);
    endcase
  end

  // Each stage loads only when its incoming valid bit is set, so bubbles never disturb held data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stg <= '0;
    end else begin
      if (i_ld[0]) r_stg[0] <= w_t;
      if (i_ld[1]) r_stg[1] <= i_a_d1 ^ r_stg[0];
      for (int j = 2; j < DEPTH; j++)
        if (i_ld[j]) r_stg[j] <= r_stg[j-1];
    end
  end

  assign o_fin = r_stg[DEPTH-1];
endmodule

module bm_dag_pipe_param #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out0,
  output logic             out1,
  output logic [15:0]      count
);
  logic [DEPTH:1]                 r_vld_pipe;
  logic [DEPTH:1][1:0]            r_mode;
  logic [WIDTH-1:0]               r_a_d1;
  logic [WIDTH-1:0]               r_out0;
  logic                           r_out1;
  logic                           r_ov;
  logic [15:0]                    r_count;
  logic [DEPTH-1:0]               w_ld;
  logic [CHANNELS-1:0][WIDTH-1:0] w_fin;
  logic [WIDTH-1:0]               w_red;

  // w_ld[j] loads stage j+1; stage 1 is fed by the accepted input
  assign w_ld = {r_vld_pipe[DEPTH-1:1], in_valid} & {DEPTH{enable}};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_mode     <= '0;
      r_a_d1     <= '0;
    end else if (enable) begin
      r_vld_pipe <= {r_vld_pipe[DEPTH-1:1], in_valid};
      if (w_ld[0]) begin
        r_mode[1] <= mode;
        r_a_d1    <= a_in;
      end
      for (int j = 2; j <= DEPTH; j++)
        if (w_ld[j-1]) r_mode[j] <= r_mode[j-1];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    bm_dag_pipe_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OP(k % 4)) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .i_ld   (w_ld),
      .i_a    (a_in),
      .i_b    (b_in),
      .i_a_d1 (r_a_d1),
      .o_fin  (w_fin[k])
    );
  end

  always_comb begin
    w_red = w_fin[0];
    for (int k = 1; k < CHANNELS; k++) begin
      case (r_mode[DEPTH])
        2'b00:   w_red = w_red & w_fin[k];
        2'b01:   w_red = w_red | w_fin[k];
        2'b10:   w_red = w_red ^ w_fin[k];
        default: w_red = w_red + w_fin[k];
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ov    <= 1'b0;
      r_out0  <= '0;
      r_out1  <= 1'b0;
      r_count <= '0;
    end else if (enable) begin
      r_ov <= r_vld_pipe[DEPTH];
      if (r_vld_pipe[DEPTH]) begin
        r_out0 <= w_red;
        r_out1 <= ^w_red;
      end
      if (r_ov) r_count <= r_count + 16'd1;
    end
  end

  // A stalled cycle hides a pending pulse; it reappears once the stall lifts
  assign out_valid = r_ov & enable;
  assign out0      = r_out0;
  assign out1      = r_out1;
  assign count     = r_count;
endmodule

// File: tb/tb_bm_dag_pipe_param.sv
// Scoreboard bench for bm_dag_pipe_param: default 4-channel instance plus a
// CHANNELS=1, DEPTH=2 instance checked directly.
module tb_bm_dag_pipe_param;
  localparam int DEPTH = 3;

  logic        clock = 1'b0;
  logic        reset_n, enable, in_valid;
  logic [7:0]  a_in, b_in;
  logic [1:0]  mode;
  logic        out_valid, out1;
  logic [7:0]  out0;
  logic [15:0] count;

  logic        iv1;
  logic [7:0]  a1, b1;
  logic [1:0]  m1;
  logic        ov1, o1_1;
  logic [7:0]  o0_1;
  logic [15:0] cnt1;

  int n_chk = 0, n_fail = 0;
  int ecnt = 0, stall_cnt = 0, pulses = 0;
  logic [7:0] last0;

  typedef struct {
    logic [7:0] e0;
    logic       e1;
    int         acc;
    int         st;
  } exp_t;
  exp_t sbq[$];

  bm_dag_pipe_param #(.WIDTH(8), .CHANNELS(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .mode(mode), .out_valid(out_valid),
    .out0(out0), .out1(out1), .count(count)
  );

  bm_dag_pipe_param #(.WIDTH(8), .CHANNELS(1), .DEPTH(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(iv1),
    .a_in(a1), .b_in(b1), .mode(m1), .out_valid(ov1),
    .out0(o0_1), .out1(o1_1), .count(cnt1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] m, input int ch);
    logic [7:0] t, s, r;
    r = '0;
    for (int k = 0; k < ch; k++) begin
      case (k % 4)
        0:       t = a & b;
        1:       t = a | b;
        2:       t = a ^ b;
        default: t = ~(a ^ b);
      endcase
      s = a ^ t;
      if (k == 0) r = s;
      else case (m)
        2'b00:   r = r & s;
        2'b01:   r = r | s;
        2'b10:   r = r ^ s;
        default: r = r + s;
      endcase
    end
    return r;
  endfunction

  always @(posedge clock) begin
    exp_t e;
    ecnt++;
    if (reset_n && enable && in_valid) begin
      e.e0  = model(a_in, b_in, mode, 4);
      e.e1  = ^e.e0;
      e.acc = ecnt;
      e.st  = stall_cnt;
      sbq.push_back(e);
    end
    if (reset_n && !enable) stall_cnt++;
    #1;
    if (!reset_n) begin
      last0 = '0;
    end else if (out_valid) begin
      pulses++;
      if (sbq.size() == 0) begin
        chk("spurious_ov", 32'(out_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("out0", 32'(out0), 32'(e.e0));
        chk("out1", 32'(out1), 32'(e.e1));
        chk("latency", 32'(ecnt - e.acc), 32'(DEPTH + stall_cnt - e.st));
      end
      last0 = out0;
    end else begin
      chk("hold_out0", 32'(out0), 32'(last0));
    end
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    @(negedge clock);
    in_valid = v; a_in = a; b_in = b; mode = m;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 2'b00);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0;
    a_in = '0; b_in = '0; mode = '0;
    iv1 = 1'b0; a1 = '0; b1 = '0; m1 = '0;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_out1", 32'(out1), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // four modes back to back
    drive(1'b1, 8'h0F, 8'h3C, 2'b00);
    drive(1'b1, 8'h0F, 8'h3C, 2'b01);
    drive(1'b1, 8'h0F, 8'h3C, 2'b10);
    drive(1'b1, 8'h0F, 8'h3C, 2'b11);
    idle(8);
    chk("modes_pulses", 32'(pulses), 32'd4);
    chk("modes_count", 32'(count), 32'd4);
    chk("modes_last", 32'(out0), 32'h32);

    // stall two cycles while the transaction sits in stage 2
    p0 = pulses;
    drive(1'b1, 8'h0F, 8'h3C, 2'b10);
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    @(negedge clock); enable = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    chk("stall_ov", 32'(out_valid), 32'd0);
    chk("stall_out0", 32'(out0), 32'h32);
    @(negedge clock);
    @(posedge clock); #1;
    chk("stall_count", 32'(count), 32'd4);
    @(negedge clock); enable = 1'b1; in_valid = 1'b0;
    idle(5);
    chk("stall_pulses", 32'(pulses - p0), 32'd1);
    chk("stall_res", 32'(out0), 32'hCC);

    // gapped valid 1,0,0,1
    p0 = pulses;
    drive(1'b1, 8'hA5, 8'h5A, 2'b11);
    drive(1'b0, 8'hFF, 8'hFF, 2'b01);
    drive(1'b0, 8'h12, 8'h34, 2'b00);
    drive(1'b1, 8'h81, 8'h7E, 2'b01);
    idle(6);
    chk("gap_pulses", 32'(pulses - p0), 32'd2);

    // async reset with two in flight
    drive(1'b1, 8'h33, 8'hC3, 2'b10);
    drive(1'b1, 8'h77, 8'h11, 2'b11);
    @(negedge clock); in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_out0", 32'(out0), 32'd0);
    chk("arst_out1", 32'(out1), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    sbq.delete();
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("arst_no_ov", 32'(out_valid), 32'd0);
    end
    chk("arst_count_after", 32'(count), 32'd0);

    // single-channel, depth-2 instance
    @(negedge clock); iv1 = 1'b1; a1 = 8'h0F; b1 = 8'h3C; m1 = 2'b10;
    @(posedge clock); #1;
    @(negedge clock); a1 = 8'hA5; b1 = 8'hFF; m1 = 2'b11;
    @(posedge clock); #1;
    chk("c1_ov_early", 32'(ov1), 32'd0);
    @(negedge clock); iv1 = 1'b0;
    @(posedge clock); #1;
    chk("c1_ov_a", 32'(ov1), 32'd1);
    chk("c1_out0_a", 32'(o0_1), 32'(model(8'h0F, 8'h3C, 2'b10, 1)));
    chk("c1_out1_a", 32'(o1_1), 32'd0);
    @(posedge clock); #1;
    chk("c1_ov_b", 32'(ov1), 32'd1);
    chk("c1_out0_b", 32'(o0_1), 32'h00);
    chk("c1_out1_b", 32'(o1_1), 32'd0);
    @(posedge clock); #1;
    chk("c1_ov_end", 32'(ov1), 32'd0);
    chk("c1_count", 32'(cnt1), 32'd2);

    // preload count to 0xFFFE, then watch it wrap
    for (int i = 0; i < 16'hFFFE; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    idle(5);
    chk("cnt_fffe", 32'(count), 32'hFFFE);
    drive(1'b1, 8'h0F, 8'h3C, 2'b11); idle(4);
    chk("cnt_ffff", 32'(count), 32'hFFFF);
    drive(1'b1, 8'h0F, 8'h3C, 2'b01); idle(4);
    chk("cnt_0000", 32'(count), 32'h0000);
    drive(1'b1, 8'h0F, 8'h3C, 2'b00); idle(4);
    chk("cnt_0001", 32'(count), 32'h0001);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
